// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: multicycle MIPS PC-update controller (PCSource/PCWrite/EPCWrite); PCSRC_STATS_EN adds taken_count
module pc_source_ctrl #(
  parameter int EXC_HOLD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_req,
  input  logic [2:0] pc_kind,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       busy,
  output logic       done,
`ifdef PCSRC_STATS_EN
  output logic [15:0] taken_count,
`endif
  output logic       illegal
);
  localparam logic [2:0] IDLE = 3'd0, EVAL = 3'd1, WRITE = 3'd2, HOLD = 3'd3, DONE = 3'd4;
  logic [2:0] state, kind;
  logic [1:0] code, cnt, d_code;
  logic       wr, exc, ill, d_wr, d_exc;
  // decision made from the latched kind and the flags seen in EVAL; overflow overrides the kind
  always_comb begin
    d_exc  = alu_ovf || kind == 3'd5;
    d_code = d_exc ? 2'b01 : kind == 3'd3 ? 2'b10 : (kind == 3'd1 || kind == 3'd2 || kind == 3'd4) ? 2'b11 : 2'b00;
    d_wr   = d_exc || kind == 3'd0 || kind == 3'd3 || kind == 3'd4 || (kind == 3'd1 && alu_zero) || (kind == 3'd2 && !alu_zero);
  end
  // request/decision sequencing; illegal kinds are latched as SEQ
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kind  <= 3'd0;
      code  <= 2'b00;
      wr    <= 1'b0;
      exc   <= 1'b0;
      ill   <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: if (pc_req) begin
          kind  <= &pc_kind[2:1] ? 3'd0 : pc_kind;
          ill   <= &pc_kind[2:1];
          state <= EVAL;
        end
        EVAL: begin
          code  <= d_code;
          wr    <= d_wr;
          exc   <= d_exc;
          state <= WRITE;
        end
        WRITE: begin
          cnt   <= 2'd0;
          state <= (exc && EXC_HOLD > 0) ? HOLD : DONE;
        end
        HOLD: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(EXC_HOLD - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign PCSource = state == WRITE ? code : state == HOLD ? 2'b01 : 2'b00;
  assign PCWrite  = state == WRITE && wr;
  assign EPCWrite = state == WRITE && exc;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign illegal  = state == EVAL && ill;
`ifdef PCSRC_STATS_EN
  // counts taken jumps/branches (codes 10 and 11) that actually write the PC
  always_ff @(posedge clk) begin
    if (reset) taken_count <= 16'd0;
    else if (PCWrite && code[1]) taken_count <= taken_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pc_source_ctrl.sv
// tb_pc_source_ctrl: scoreboard bench for pc_source_ctrl (optionally PCSRC_STATS_EN)
module tb_pc_source_ctrl;
  localparam int H = 2;
  logic       clk = 0, reset = 1, pc_req = 0, alu_zero = 0, alu_ovf = 0;
  logic [2:0] pc_kind = 0;
  logic [1:0] PCSource;
  logic       PCWrite, EPCWrite, busy, done, illegal;
  logic [6:0] q[$];
  int         vectors = 0, errors = 0;
`ifdef PCSRC_STATS_EN
  logic [15:0] taken_count, tc_exp = 0;
`endif
  pc_source_ctrl #(.EXC_HOLD(H)) dut (
    .clk(clk), .reset(reset), .pc_req(pc_req), .pc_kind(pc_kind), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .PCSource(PCSource), .PCWrite(PCWrite), .EPCWrite(EPCWrite), .busy(busy), .done(done),
`ifdef PCSRC_STATS_EN
    .taken_count(taken_count),
`endif
    .illegal(illegal));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // {PCSource, PCWrite, EPCWrite, busy, done, illegal}
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) chk("cycle", {25'd0, PCSource, PCWrite, EPCWrite, busy, done, illegal}, {25'd0, q.pop_front()});
  end
  task automatic issue(input logic [2:0] k, input logic z, input logic o, input int poke);
    logic [2:0] kk;
    logic [1:0] c;
    logic       w, e, il;
    int         n;
    il = k[2] & k[1];
    kk = il ? 3'd0 : k;
    e  = o || kk == 3'd5;
    c  = e ? 2'b01 : kk == 3'd3 ? 2'b10 : (kk == 3'd1 || kk == 3'd2 || kk == 3'd4) ? 2'b11 : 2'b00;
    w  = e || kk == 3'd0 || kk == 3'd3 || kk == 3'd4 || (kk == 3'd1 && z) || (kk == 3'd2 && !z);
    n  = e ? H : 0;
`ifdef PCSRC_STATS_EN
    if (w && c[1]) tc_exp++;
`endif
    q.push_back({2'b00, 1'b0, 1'b0, 1'b1, 1'b0, il});
    q.push_back({c, w, e, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < n; i++) q.push_back({2'b01, 4'b0010, 1'b0});
    q.push_back({2'b00, 4'b0011, 1'b0});
    q.push_back(7'd0);
    pc_req  = 1;
    pc_kind = k;
    for (int i = 1; i <= 3 + n; i++) begin
      @(negedge clk);
      pc_req = (poke == i);
      if (i == 1) begin
        alu_zero = z;
        alu_ovf  = o;
        pc_kind  = 3'd5;
      end
    end
    @(negedge clk);
    pc_req = 0;
  endtask
  initial begin
    q.push_back(7'd0);
    q.push_back(7'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    issue(3'd1, 1, 0, 0);
    issue(3'd1, 0, 0, 0);
    issue(3'd2, 1, 0, 0);
    issue(3'd2, 0, 0, 0);
    issue(3'd0, 0, 0, 0);
    issue(3'd3, 1, 0, 0);
    issue(3'd4, 0, 0, 0);
    issue(3'd5, 1, 0, 0);
    issue(3'd0, 0, 1, 0);
    issue(3'd1, 0, 1, 0);
    issue(3'd7, 0, 0, 1);
    issue(3'd6, 1, 0, 3);
    issue(3'd5, 0, 0, 3 + H);
    for (int i = 0; i < 20; i++)
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)));
`ifdef PCSRC_STATS_EN
    chk("taken_count", {16'd0, taken_count}, {16'd0, tc_exp});
`endif
    pc_req  = 1;
    pc_kind = 3'd3;
    q.push_back({2'b00, 4'b0010, 1'b0});
    q.push_back({2'b10, 4'b1010, 1'b0});
    q.push_back(7'd0);
    q.push_back(7'd0);
    @(negedge clk);
    pc_req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
`ifdef PCSRC_STATS_EN
    tc_exp = 0;
`endif
    @(negedge clk);
    issue(3'd4, 0, 0, 0);
    issue(3'd3, 0, 0, 0);
`ifdef PCSRC_STATS_EN
    chk("taken_count_after_reset", {16'd0, taken_count}, {16'd0, tc_exp});
`endif
    repeat (2) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
